// File: rtl/acc_sequencer.sv
// Accumulator-machine sequencer: fetches 16-opcode instructions over a
// req/ack memory handshake and executes them against a single accumulator.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// FETCH  | reading instruction at PC
// DECODE | one cycle to route on opcode
// OPREAD | reading memory operand at A into MBR
// EXEC   | one cycle to update AC/PC or halt
// WRITE  | storing AC to A
// HALT   | stopped; start resumes at PC
module acc_sequencer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 12,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc
);

  if (DATA_W < ADDR_W + 4) begin : g_width_check
    $error("acc_sequencer: DATA_W must be at least ADDR_W+4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPREAD,
    S_EXEC,
    S_WRITE,
    S_HALT
  } state_t;

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            state_q, state_nxt;
  logic [DATA_W-1:0] ir_q, ir_nxt;
  logic [DATA_W-1:0] mbr_q, mbr_nxt;
  logic [DATA_W-1:0] ac_q, ac_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic              illegal_q, illegal_nxt;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] opa;
  logic              unused_ir;

  assign opcode    = ir_q[DATA_W-1 -: 4];
  assign opa       = ir_q[ADDR_W-1:0];
  // Bits between opcode and operand carry no meaning.
  assign unused_ir = ^ir_q;

  assign mem_wdata = ac_q;
  assign pc        = pc_q;
  assign acc       = ac_q;
  assign illegal   = illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      mbr_q     <= '0;
      ac_q      <= '0;
      pc_q      <= PC_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      ir_q      <= ir_nxt;
      mbr_q     <= mbr_nxt;
      ac_q      <= ac_nxt;
      pc_q      <= pc_nxt;
      illegal_q <= illegal_nxt;
    end
  end

  // Handshake outputs depend only on registered state, so they hold
  // steady for however long the memory withholds ack.
  always_comb begin
    state_nxt   = state_q;
    ir_nxt      = ir_q;
    mbr_nxt     = mbr_q;
    ac_nxt      = ac_q;
    pc_nxt      = pc_q;
    illegal_nxt = illegal_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc_q;
    busy        = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          state_nxt   = S_FETCH;
          illegal_nxt = 1'b0;
        end
      end

      S_FETCH: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_nxt    = mem_rdata;
          pc_nxt    = pc_q + PC_ONE;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        busy = 1'b1;
        case (opcode)
          4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_nxt = S_OPREAD;
          4'h2:                               state_nxt = S_WRITE;
          default:                            state_nxt = S_EXEC;
        endcase
      end

      S_OPREAD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = opa;
        if (mem_ack) begin
          mbr_nxt   = mem_rdata;
          state_nxt = S_EXEC;
        end
      end

      S_WRITE: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = opa;
        if (mem_ack) state_nxt = S_FETCH;
      end

      S_EXEC: begin
        busy      = 1'b1;
        state_nxt = S_FETCH;
        case (opcode)
          4'h0: state_nxt = S_HALT;
          4'h1: ac_nxt = mbr_q;
          4'h3: ac_nxt = ac_q + mbr_q;
          4'h4: ac_nxt = ac_q - mbr_q;
          4'h5: ac_nxt = ac_q & mbr_q;
          4'h6: ac_nxt = ac_q | mbr_q;
          4'h7: ac_nxt = ac_q ^ mbr_q;
          4'h8: pc_nxt = opa;
          4'h9: if (ac_q == '0) pc_nxt = pc_q + PC_ONE;
          4'hA: if (ac_q[DATA_W-1]) pc_nxt = pc_q + PC_ONE;
          4'hB: ac_nxt = ac_q << 1;
          4'hC: ac_nxt = ac_q >> 1;
          4'hD: ac_nxt = '0;
          4'hE: ac_nxt = {{(DATA_W-ADDR_W){1'b0}}, opa};
          4'hF: begin
            state_nxt   = S_HALT;
            illegal_nxt = 1'b1;
          end
          default: state_nxt = S_FETCH;
        endcase
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: an instruction-level model predicts the memory
// transaction stream, cycle count and final state of each program run.
module tb_acc_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, acc;
  logic        busy, halted, illegal;

  acc_sequencer #(.DATA_W(16), .ADDR_W(12), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .halted(halted), .illegal(illegal), .pc(pc), .acc(acc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem [4096];
  int          cur_delay, wait_cnt, delay_mode;
  logic        stray_ack;

  assign mem_ack   = mem_req ? (wait_cnt >= cur_delay) : stray_ack;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      wait_cnt  <= 0;
      cur_delay <= (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt  <= 0;
      cur_delay <= (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
    end
  end

  // ---------------- instruction-level model ----------------
  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [15:0] mm [4096];
  logic [11:0] m_pc;
  logic [15:0] m_ac;
  logic        m_illegal;
  int          exp_cycles;

  task automatic model_reset();
    m_pc = 12'h000; m_ac = 16'h0000; m_illegal = 1'b0;
  endtask

  task automatic model_run();
    logic [15:0] ir, mbr;
    logic [3:0]  op;
    logic [11:0] a;
    bit          done;
    int          n;
    done = 0; n = 0; mbr = '0;
    m_illegal  = 1'b0;
    exp_cycles = 0;
    for (int i = 0; i < 4096; i++) mm[i] = mem[i];
    while (!done && n < 1000) begin
      n++;
      exp_q.push_back('{1'b0, m_pc, 16'h0});
      ir   = mm[m_pc];
      m_pc = m_pc + 12'd1;
      op   = ir[15:12];
      a    = ir[11:0];
      if (op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7}) begin
        exp_q.push_back('{1'b0, a, 16'h0});
        mbr = mm[a];
        exp_cycles += 4;
      end else begin
        exp_cycles += 3;
      end
      case (op)
        4'h0: done = 1;
        4'h1: m_ac = mbr;
        4'h2: begin exp_q.push_back('{1'b1, a, m_ac}); mm[a] = m_ac; end
        4'h3: m_ac = m_ac + mbr;
        4'h4: m_ac = m_ac - mbr;
        4'h5: m_ac = m_ac & mbr;
        4'h6: m_ac = m_ac | mbr;
        4'h7: m_ac = m_ac ^ mbr;
        4'h8: m_pc = a;
        4'h9: if (m_ac == 16'h0) m_pc = m_pc + 12'd1;
        4'hA: if (m_ac[15]) m_pc = m_pc + 12'd1;
        4'hB: m_ac = {m_ac[14:0], 1'b0};
        4'hC: m_ac = {1'b0, m_ac[15:1]};
        4'hD: m_ac = 16'h0;
        4'hE: m_ac = {4'h0, a};
        default: begin done = 1; m_illegal = 1'b1; end
      endcase
    end
  endtask

  // ---------------- per-cycle compare ----------------
  int          busy_cycles, wait_cycles, txn_count;
  logic [11:0] first_addr;
  logic        prev_wait, prev_read_ack, p_we;
  logic [11:0] p_addr;
  logic [15:0] p_wdata;
  txn_t        t;

  always @(negedge clk) begin
    if (reset) begin
      prev_wait     = 1'b0;
      prev_read_ack = 1'b0;
      exp_q.delete();
    end else begin
      chk("wdata_is_acc", 32'(mem_wdata), 32'(acc));
      chk("we_without_req", 32'(mem_we & ~mem_req), 32'd0);
      chk("busy_and_halted", 32'(busy & halted), 32'd0);
      if (prev_wait) begin
        chk("hold_req", 32'(mem_req), 32'd1);
        chk("hold_addr", 32'(mem_addr), 32'(p_addr));
        chk("hold_we", 32'(mem_we), 32'(p_we));
        chk("hold_wdata", 32'(mem_wdata), 32'(p_wdata));
      end
      if (prev_read_ack) chk("req_drop_after_read", 32'(mem_req), 32'd0);
      if (mem_req && mem_ack) begin
        chk("txn_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          chk("txn_we", 32'(mem_we), 32'(t.we));
          chk("txn_addr", 32'(mem_addr), 32'(t.addr));
          if (t.we) chk("txn_wdata", 32'(mem_wdata), 32'(t.wdata));
        end
        if (txn_count == 0) first_addr = mem_addr;
        txn_count++;
      end
      if (busy) busy_cycles++;
      if (mem_req && !mem_ack) wait_cycles++;
      prev_wait     = mem_req && !mem_ack;
      prev_read_ack = mem_req && mem_ack && !mem_we;
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wdata = mem_wdata;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic run_prog(output int bc, output logic ill_at_start);
    int n;
    model_run();
    busy_cycles = 0; wait_cycles = 0; txn_count = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ill_at_start = illegal;
    n = 0;
    while (!halted && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("halt_within_budget", 32'(n < 5000), 32'd1);
    chk("run_halted", 32'(halted), 32'd1);
    chk("run_pc", 32'(pc), 32'(m_pc));
    chk("run_acc", 32'(acc), 32'(m_ac));
    chk("run_illegal", 32'(illegal), 32'(m_illegal));
    chk("run_txn_all_seen", 32'(exp_q.size()), 32'd0);
    chk("run_cycles", 32'(busy_cycles), 32'(exp_cycles + wait_cycles));
    bc = busy_cycles;
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'h2012; mem[3] = 16'h0000;
    mem[12'h010] = 16'h7FFF; mem[12'h011] = 16'h0002;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bc, n, len;
    logic        ill0;
    logic [3:0]  op;
    logic [11:0] a;

    reset = 1'b1; start = 1'b0; stray_ack = 1'b0; delay_mode = 0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_mem_addr", 32'(mem_addr), 32'h000);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    clear_mem();
    do_reset();

    // Basic program, zero wait.
    load_basic();
    run_prog(bc, ill0);
    chk("basic_model_cycles", 32'(exp_cycles), 32'd14);
    chk("basic_cycles", 32'(bc), 32'd14);
    chk("basic_pc", 32'(pc), 32'h004);
    chk("basic_acc", 32'(acc), 32'h8001);
    chk("basic_store", 32'(mem[12'h012]), 32'h8001);

    // Same program, three wait cycles on every request.
    do_reset();
    load_basic();
    delay_mode = 3;
    run_prog(bc, ill0);
    chk("wait_waits", 32'(wait_cycles), 32'd21);
    chk("wait_cycles", 32'(bc), 32'd35);
    chk("wait_pc", 32'(pc), 32'h004);
    chk("wait_acc", 32'(acc), 32'h8001);
    chk("wait_store", 32'(mem[12'h012]), 32'h8001);
    delay_mode = 0;

    // PC wrap: park at 5, then JUMP to 0xFFF and fall through to 0.
    do_reset();
    clear_mem();
    mem[0] = 16'h8004; mem[4] = 16'h0000;
    run_prog(bc, ill0);
    chk("wrap_setup_pc", 32'(pc), 32'h005);
    mem[0] = 16'h9000; mem[1] = 16'h0000; mem[2] = 16'h0000;
    mem[5] = 16'h8FFF; mem[12'hFFF] = 16'hD000;
    run_prog(bc, ill0);
    chk("wrap_pc", 32'(pc), 32'h003);
    chk("wrap_acc", 32'(acc), 32'h0000);

    // Illegal opcode, then restart.
    do_reset();
    clear_mem();
    mem[0] = 16'hF123;
    run_prog(bc, ill0);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_pc", 32'(pc), 32'h001);
    mem[1] = 16'hE055; mem[2] = 16'h0000;
    run_prog(bc, ill0);
    chk("ill_cleared_on_start", 32'(ill0), 32'd0);
    chk("ill_resume_addr", 32'(first_addr), 32'h001);
    chk("ill_resume_pc", 32'(pc), 32'h003);
    chk("ill_resume_acc", 32'(acc), 32'h0055);

    // Reset while an operand read is pending.
    do_reset();
    clear_mem();
    mem[0] = 16'h1010; mem[12'h010] = 16'h1234;
    model_run();
    delay_mode = 20;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!(mem_req && mem_addr == 12'h010) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("opread_reached", 32'(mem_req && mem_addr == 12'h010), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_pc", 32'(pc), 32'h000);
    chk("async_rst_acc", 32'(acc), 32'h0000);
    chk("async_rst_addr", 32'(mem_addr), 32'h000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", 32'(mem_req), 32'd0);
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_halted", 32'(halted), 32'd0);
    chk("late_ack_pc", 32'(pc), 32'h000);
    chk("late_ack_acc", 32'(acc), 32'h0000);
    delay_mode = 0;

    // Random terminating programs with forward-only jumps.
    for (int p = 0; p < 25; p++) begin
      do_reset();
      clear_mem();
      delay_mode = (p % 2 == 1) ? -1 : 0;
      len = int'($urandom_range(4, 20));
      for (int i = 0; i < 16; i++) mem[12'h100 + 12'(i)] = 16'($urandom);
      for (int i = 0; i < len; i++) begin
        op = 4'($urandom_range(1, 14));
        if (op == 4'h8)      a = 12'($urandom_range(i + 1, len));
        else if (op == 4'hE) a = 12'($urandom);
        else                 a = 12'h100 + 12'($urandom_range(0, 15));
        mem[i] = {op, a};
      end
      mem[len]     = ($urandom_range(0, 1) == 1) ? 16'hF000 : 16'h0000;
      mem[len + 1] = 16'h0000;
      mem[len + 2] = 16'h0000;
      run_prog(bc, ill0);
      if (!halted) break;
    end
    delay_mode = 0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, datapath/word width; SHALL satisfy DATA_W >= ADDR_W+4, else elaboration error.
REQ-002 Parameter ADDR_W, default 12, memory address width; PC, MAR and operand field width.
REQ-003 Parameter START_ADDR, default 0, PC value loaded by reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  run request; sampled only in IDLE or HALT.
REQ-007 mem_req  out  1  memory transaction request.
REQ-008 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-009 mem_addr  out  ADDR_W  transaction address.
REQ-010 mem_wdata  out  DATA_W  write data (AC).
REQ-011 mem_rdata  in  DATA_W  read data; valid in cycle mem_ack=1.
REQ-012 mem_ack  in  1  transaction complete.
REQ-013 busy  out  1  high in FETCH, DECODE, OPREAD, EXEC, WRITE.
REQ-014 halted  out  1  high in HALT.
REQ-015 illegal  out  1  sticky: last halt caused by opcode 0xF.
REQ-016 pc  out  ADDR_W  program counter.
REQ-017 acc  out  DATA_W  accumulator.

Function
REQ-018 Instruction: opcode = IR[DATA_W-1 -: 4]; operand field A = IR[ADDR_W-1:0]; bits between ignored.
REQ-019 States SHALL be IDLE, FETCH, DECODE, OPREAD, EXEC, WRITE, HALT; state held in registers.
REQ-020 IDLE/HALT: start=1 -> FETCH; start elsewhere ignored.
REQ-021 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ack: IR<=mem_rdata, PC<=PC+1 mod 2^ADDR_W, -> DECODE.
REQ-022 DECODE (1 cycle): opcodes 1,3,4,5,6,7 -> OPREAD; opcode 2 -> WRITE; all others -> EXEC.
REQ-023 OPREAD: mem_req=1, mem_we=0, mem_addr=A; on mem_ack: MBR<=mem_rdata, -> EXEC.
REQ-024 WRITE: mem_req=1, mem_we=1, mem_addr=A, mem_wdata=AC; on mem_ack -> FETCH.
REQ-025 EXEC (1 cycle), then -> FETCH unless noted: 0 HALT -> HALT; 1 LOAD AC<=MBR; 3 ADD AC<=AC+MBR; 4 SUB AC<=AC-MBR; 5 AND; 6 OR; 7 XOR (AC op MBR); 8 JUMP PC<=A; 9 SKIPZ PC<=PC+1 if AC==0; 0xA SKIPNEG PC<=PC+1 if AC[DATA_W-1]=1; 0xB SHL AC<=AC<<1; 0xC SHR AC<=AC>>1 logical; 0xD CLEAR AC<=0; 0xE LOADI AC<=zero-extended A; 0xF -> HALT, illegal<=1.
REQ-026 Arithmetic modulo 2^DATA_W; carry/borrow discarded; PC increments and skips wrap 2^ADDR_W-1 -> 0.
REQ-027 Handshake: mem_req, mem_we, mem_addr, mem_wdata SHALL stay constant from request cycle through ack cycle; no timeout; arbitrary wait cycles.
REQ-028 mem_req SHALL be 0 in the cycle after an ack unless the next state issues a new request (FETCH after WRITE/EXEC re-asserts immediately).
REQ-029 mem_ack while mem_req=0 SHALL be ignored.
REQ-030 Zero-wait latency: register-only ops 3 cycles, STORE 3, memory-operand ops 4.
REQ-031 Restart from HALT SHALL resume at current PC (instruction after HALT), clear illegal, keep AC.
REQ-032 mem_wdata SHALL equal AC in all states; mem_we=0 when mem_req=0.

Reset
REQ-033 reset=1 SHALL immediately (without clk) force IDLE, mem_req=0, mem_we=0, busy=0, halted=0, illegal=0, AC=0, IR=0, MBR=0, PC=START_ADDR, mem_addr=START_ADDR.
REQ-034 Reset mid-transaction SHALL abandon it; a late mem_ack after reset SHALL be ignored.

Verification (DATA_W=16, ADDR_W=12, START_ADDR=0, zero-wait ack unless stated)
REQ-035 Assert reset -> all outputs at REQ-033 values, pc=0x000, mem_req=0, no clk needed.
REQ-036 mem[0]=0x1010, [1]=0x3011, [2]=0x2012, [3]=0x0000, [0x10]=0x7FFF, [0x11]=0x0002; pulse start -> single write 0x8001 to 0x012, halted=1 14 cycles after start accepted, pc=0x004, acc=0x8001.
REQ-037 Same program, ack delayed 3 cycles per request -> mem_req/addr/we stable through each wait, identical final state, no state advance while waiting.
REQ-038 PC=0xFFF via JUMP 0x8FFF, mem[0xFFF]=0xD000 (CLEAR), mem[0]=0x9000 (SKIPZ), mem[1]=0x0000, mem[2]=0x0000 -> fetch wraps to 0x000, skip taken, halts with pc=0x003.
REQ-039 mem[0]=0xF123 -> halted=1, illegal=1, pc=0x001; start again -> illegal=0, fetch from 0x001.
REQ-040 Reset asserted in OPREAD with mem_req=1 and ack withheld -> mem_req falls asynchronously, state IDLE; subsequent mem_ack pulse causes no change.
